// File: rtl/microseq_cpu_core_if.sv
// ---------------------------------------------------------------------------
// microseq_cpu_core_if
// Memory port between the microsequenced CPU core and external memory.
//   mem_addr  : word address, held from the core's AR
//   mem_rd    : read request
//   mem_wr    : write request (never high together with mem_rd)
//   mem_wdata : write data, held from the core's AC
//   mem_rdata : read data, valid when mem_ready=1
//   mem_ready : the access completes on the rising edge where it is 1
// Modports: master = CPU core, slave = memory.
// ---------------------------------------------------------------------------
interface microseq_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  localparam int ADDR_W = DATA_W - OP_W;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/microseq_cpu_core.sv
// ---------------------------------------------------------------------------
// microseq_cpu_core
// Microsequenced accumulator CPU with an 8-instruction set (ADD, AND, JMP,
// INC, CLR, JZ, STA, HLT), carry/zero flags and a ready-handshaked memory
// port. Instruction word = {opcode[OP_W], operand[ADDR_W]}.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset   : asynchronous, active-low reset
//   bus     : memory port (microseq_cpu_core_if.master)
//   pc_o    : program counter
//   ac_o    : accumulator
//   carry_o : carry flag
//   zero_o  : AC == 0 (combinational)
//   halted  : 1 while in the HALT state
// ---------------------------------------------------------------------------
module microseq_cpu_core #(
  parameter  int DATA_W = 8,
  parameter  int OP_W   = 3,
  localparam int ADDR_W = DATA_W - OP_W
) (
  input  logic                clk,
  input  logic                reset,
  microseq_cpu_core_if.master bus,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [DATA_W-1:0]   ac_o,
  output logic                carry_o,
  output logic                zero_o,
  output logic                halted
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(1);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(2);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(3);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(6);

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3,
    S_ADD1, S_ADD2, S_AND1, S_AND2,
    S_JMP1, S_INC1, S_CLR1, S_JZ1, S_STA1,
    S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, ar;
  logic [DATA_W-1:0] dr, ac;
  logic [OP_W-1:0]   ir;
  logic              c;
  logic              mem_rd_c, mem_wr_c, halted_c;

  // {carry, sum} of two DATA_W-bit operands
  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Accumulator/carry update for the ALU execute states, selected by IR.
  // AND leaves the carry untouched; CLR clears both.
  function automatic logic [DATA_W:0] alu(input logic [OP_W-1:0]   op,
                                          input logic              c_in,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      OP_ADD:  r = add_carry(a, b);
      OP_AND:  r = {c_in, a & b};
      OP_INC:  r = add_carry(a, DATA_W'(1));
      OP_CLR:  r = '0;
      default: r = {c_in, a};
    endcase
    return r;
  endfunction

  // Execute-state entry point for an opcode (used in FETCH3 on the fresh DR)
  function automatic state_t decode(input logic [OP_W-1:0] op);
    state_t s;
    case (op)
      OP_ADD:  s = S_ADD1;
      OP_AND:  s = S_AND1;
      OP_JMP:  s = S_JMP1;
      OP_INC:  s = S_INC1;
      OP_CLR:  s = S_CLR1;
      OP_JZ:   s = S_JZ1;
      OP_STA:  s = S_STA1;
      default: s = S_HALT;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH1;
    else        state <= state_nxt;
  end

  // Next-state logic; access states hold until mem_ready
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: if (bus.mem_ready) state_nxt = S_FETCH3;
      S_FETCH3: state_nxt = decode(dr[DATA_W-1 -: OP_W]);
      S_ADD1:   if (bus.mem_ready) state_nxt = S_ADD2;
      S_AND1:   if (bus.mem_ready) state_nxt = S_AND2;
      S_STA1:   if (bus.mem_ready) state_nxt = S_FETCH1;
      S_ADD2, S_AND2, S_JMP1, S_INC1, S_CLR1, S_JZ1:
                state_nxt = S_FETCH1;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH1;
    endcase
  end

  // Output decode: requests depend on state only, so they are mutually
  // exclusive and address/data stay stable for the whole request.
  always_comb begin
    mem_rd_c = 1'b0;
    mem_wr_c = 1'b0;
    halted_c = 1'b0;
    case (state)
      S_FETCH2, S_ADD1, S_AND1: mem_rd_c = 1'b1;
      S_STA1:                   mem_wr_c = 1'b1;
      S_HALT:                   halted_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      ar <= '0;
      dr <= '0;
      ir <= '0;
      ac <= '0;
      c  <= 1'b0;
    end else begin
      case (state)
        S_FETCH1: ar <= pc;
        S_FETCH2: if (bus.mem_ready) begin
          dr <= bus.mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_FETCH3: begin
          ir <= dr[DATA_W-1 -: OP_W];
          ar <= dr[ADDR_W-1:0];
        end
        S_ADD1, S_AND1: if (bus.mem_ready) dr <= bus.mem_rdata;
        S_ADD2, S_AND2, S_INC1, S_CLR1: {c, ac} <= alu(ir, c, ac, dr);
        S_JMP1: pc <= ar;
        S_JZ1:  if (ac == '0) pc <= ar;
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = ar;
  assign bus.mem_wdata = ac;
  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;

  assign pc_o    = pc;
  assign ac_o    = ac;
  assign carry_o = c;
  assign zero_o  = (ac == '0);
  assign halted  = halted_c;

endmodule

// File: tb/tb_microseq_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_microseq_cpu_core
// Directed bench for microseq_cpu_core: behavioural memory with programmable
// wait states, a sequence of small programs, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_microseq_cpu_core;

  logic       clk;
  logic       reset;
  logic [4:0] pc_o;
  logic [7:0] ac_o;
  logic       carry_o;
  logic       zero_o;
  logic       halted;

  logic [7:0] mem [0:31];
  int         wait_n;
  logic       stall_all;
  int         wcnt;
  int         wr_cnt;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks;
  int n_errors;

  microseq_cpu_core_if #(.DATA_W(8), .OP_W(3)) bus ();

  microseq_cpu_core #(.DATA_W(8), .OP_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pc_o    (pc_o),
    .ac_o    (ac_o),
    .carry_o (carry_o),
    .zero_o  (zero_o),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, ready after wait_n stalled cycles
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = !stall_all && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (!(bus.mem_rd || bus.mem_wr) || bus.mem_ready) wcnt <= 0;
    else                                               wcnt <= wcnt + 1;
    if (reset && bus.mem_wr && bus.mem_ready) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.mem_addr;
      wr_data <= bus.mem_wdata;
    end
  end

  initial begin
    wcnt   = 0;
    wr_cnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Hold reset, clear memory; program is written afterwards by the caller
  task automatic hold_reset();
    @(negedge clk);
    reset     = 1'b0;
    stall_all = 1'b0;
    wait_n    = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  int snap;
  int rd_seen;
  int wr_seen;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    stall_all = 1'b0;
    wait_n    = 0;

    // ---- reset state ----
    hold_reset();
    #1;
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_ac", 32'(ac_o), 32'h0);
    chk("rst_c", 32'(carry_o), 32'h0);
    chk("rst_zero", 32'(zero_o), 32'h1);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_rd", 32'(bus.mem_rd), 32'h0);
    chk("rst_wr", 32'(bus.mem_wr), 32'h0);

    // ---- straight-line program, ready=1 ----
    mem[0] = 8'h80; mem[1] = 8'h10; mem[2] = 8'h11; mem[3] = 8'hD2; mem[4] = 8'hE0;
    mem[16] = 8'hF0; mem[17] = 8'h20;
    snap = wr_cnt;
    release_reset();
    tick(21);
    chk("prog_halted", 32'(halted), 32'h1);
    chk("prog_ac", 32'(ac_o), 32'h10);
    chk("prog_c", 32'(carry_o), 32'h1);
    chk("prog_pc", 32'(pc_o), 32'h5);
    chk("prog_zero", 32'(zero_o), 32'h0);
    chk("prog_wr_cnt", 32'(wr_cnt - snap), 32'h1);
    chk("prog_wr_addr", 32'(wr_addr), 32'd18);
    chk("prog_wr_data", 32'(wr_data), 32'h10);
    rd_seen = 0;
    wr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      rd_seen += int'(bus.mem_rd);
      wr_seen += int'(bus.mem_wr);
    end
    chk("halt_no_rd", 32'(rd_seen), 32'h0);
    chk("halt_no_wr", 32'(wr_seen), 32'h0);
    chk("halt_pc", 32'(pc_o), 32'h5);
    chk("halt_ac", 32'(ac_o), 32'h10);

    // ---- wait states: ADD 16 with 3 wait cycles per access ----
    hold_reset();
    mem[0] = 8'h10; mem[16] = 8'h05;
    wait_n = 3;
    release_reset();
    tick(3);
    chk("ws_f_rd", 32'(bus.mem_rd), 32'h1);
    chk("ws_f_addr", 32'(bus.mem_addr), 32'h0);
    chk("ws_f_pc", 32'(pc_o), 32'h0);
    tick(5);
    chk("ws_x_rd", 32'(bus.mem_rd), 32'h1);
    chk("ws_x_addr", 32'(bus.mem_addr), 32'd16);
    chk("ws_x_pc", 32'(pc_o), 32'h1);
    chk("ws_x_ac", 32'(ac_o), 32'h0);
    tick(2);
    chk("ws_10_ac", 32'(ac_o), 32'h0);
    tick(1);
    chk("ws_11_ac", 32'(ac_o), 32'h05);
    chk("ws_11_pc", 32'(pc_o), 32'h1);

    // ---- JZ taken / not taken ----
    hold_reset();
    mem[0] = 8'hA7; mem[7] = 8'h60; mem[8] = 8'hA3; mem[9] = 8'hE0;
    release_reset();
    tick(4);
    chk("jz_taken_pc", 32'(pc_o), 32'h7);
    tick(4);
    chk("inc_ac", 32'(ac_o), 32'h1);
    chk("inc_zero", 32'(zero_o), 32'h0);
    chk("inc_c", 32'(carry_o), 32'h0);
    tick(4);
    chk("jz_not_pc", 32'(pc_o), 32'h9);
    tick(3);
    chk("jz_halted", 32'(halted), 32'h1);
    chk("jz_halt_pc", 32'(pc_o), 32'hA);

    // ---- PC and AC wrap ----
    hold_reset();
    mem[0] = 8'h14; mem[1] = 8'h5F; mem[31] = 8'h60; mem[20] = 8'hFF;
    release_reset();
    tick(5);
    chk("wrap_ac_ff", 32'(ac_o), 32'hFF);
    chk("wrap_c0", 32'(carry_o), 32'h0);
    tick(4);
    chk("wrap_jmp_pc", 32'(pc_o), 32'd31);
    tick(2);
    chk("wrap_pc0", 32'(pc_o), 32'h0);
    tick(2);
    chk("wrap_ac0", 32'(ac_o), 32'h0);
    chk("wrap_c1", 32'(carry_o), 32'h1);
    chk("wrap_zero", 32'(zero_o), 32'h1);

    // ---- AND keeps carry, CLR clears it ----
    hold_reset();
    mem[0] = 8'h14; mem[1] = 8'h15; mem[2] = 8'h36; mem[3] = 8'h80; mem[4] = 8'hE0;
    mem[20] = 8'hFF; mem[21] = 8'h3D; mem[22] = 8'h0F;
    release_reset();
    tick(10);
    chk("and_pre_ac", 32'(ac_o), 32'h3C);
    chk("and_pre_c", 32'(carry_o), 32'h1);
    tick(5);
    chk("and_ac", 32'(ac_o), 32'h0C);
    chk("and_c", 32'(carry_o), 32'h1);
    tick(4);
    chk("clr_ac", 32'(ac_o), 32'h0);
    chk("clr_c", 32'(carry_o), 32'h0);

    // ---- reset during ADD2 ----
    hold_reset();
    mem[0] = 8'h10; mem[16] = 8'hF0;
    release_reset();
    tick(4);
    chk("add2_pre_pc", 32'(pc_o), 32'h1);
    chk("add2_pre_addr", 32'(bus.mem_addr), 32'd16);
    reset = 1'b0;
    #1;
    chk("add2_rst_pc", 32'(pc_o), 32'h0);
    chk("add2_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("add2_rst_ac", 32'(ac_o), 32'h0);
    chk("add2_rst_rd", 32'(bus.mem_rd), 32'h0);
    release_reset();
    tick(1);
    chk("add2_post_rd", 32'(bus.mem_rd), 32'h1);
    chk("add2_post_addr", 32'(bus.mem_addr), 32'h0);

    // ---- reset during a stalled STA ----
    hold_reset();
    mem[0] = 8'h10; mem[1] = 8'hD2; mem[16] = 8'hF0;
    release_reset();
    tick(8);
    stall_all = 1'b1;
    tick(3);
    chk("sta_stall_wr", 32'(bus.mem_wr), 32'h1);
    chk("sta_stall_addr", 32'(bus.mem_addr), 32'd18);
    chk("sta_stall_wdata", 32'(bus.mem_wdata), 32'hF0);
    chk("sta_stall_pc", 32'(pc_o), 32'h2);
    snap = wr_cnt;
    reset = 1'b0;
    #1;
    chk("sta_rst_wr", 32'(bus.mem_wr), 32'h0);
    chk("sta_rst_pc", 32'(pc_o), 32'h0);
    chk("sta_rst_ac", 32'(ac_o), 32'h0);
    chk("sta_rst_c", 32'(carry_o), 32'h0);
    chk("sta_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("sta_rst_halted", 32'(halted), 32'h0);
    stall_all = 1'b0;
    release_reset();
    tick(1);
    chk("sta_post_rd", 32'(bus.mem_rd), 32'h1);
    chk("sta_post_addr", 32'(bus.mem_addr), 32'h0);
    chk("sta_no_write", 32'(wr_cnt - snap), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
